// File: rtl/pts_tx.sv
`default_nettype none
// ============================================================================
// Module   : pts_tx
// Purpose  : Parallel-to-serial transmitter. Accepts a NUM_BITS-wide word
//            over a ready/load handshake and shifts it out LSB-first, one
//            bit per CLKS_PER_BIT-cycle bit period. The last cycle of every
//            bit period carries a one-cycle shift strobe, so the data/strobe
//            pair can drive a serial-to-parallel receiver's serial-data and
//            shift-enable inputs directly.
//
// Parameters:
//   NUM_BITS        word width in bits (>= 2)
//   CLKS_PER_BIT    clock cycles per serial bit period (>= 1)
//
// Ports:
//   clk              in   system clock, all state on the rising edge
//   n_rst            in   asynchronous active-low reset
//   tx_load          in   request to load tx_parallel (honoured only in IDLE)
//   tx_parallel      in   word to transmit, sampled on an accepted load
//   tx_abort         in   abandon the current transfer
//   tx_ready         out  a load presented this cycle will be accepted
//   tx_data          out  serial data bit (0 outside a transfer)
//   tx_shift_enable  out  one-cycle strobe, receiver samples tx_data now
//   tx_done          out  one-cycle pulse the cycle after the last strobe
//
// Revision : 1.0  initial release
// ============================================================================
module pts_tx #(
    parameter int NUM_BITS     = 128,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_load,
    input  logic [NUM_BITS-1:0] tx_parallel,
    input  logic                tx_abort,
    output logic                tx_ready,
    output logic                tx_data,
    output logic                tx_shift_enable,
    output logic                tx_done
);

    // ------------------------------------------------------------------------
    // Counter widths. The period counter keeps at least one bit so that the
    // CLKS_PER_BIT = 1 case still has a legal (always-zero) counter; in that
    // case every SEND cycle is a strobe cycle.
    // ------------------------------------------------------------------------
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(NUM_BITS - 1);
    localparam logic [PER_W-1:0] c_last_per = PER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_BITS-1:0] r_sr;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [PER_W-1:0]    r_per_cnt;

    // Last cycle of the current bit period while sending.
    logic w_strobe;
    assign w_strobe = (r_state == ST_SEND) && (r_per_cnt == c_last_per);

    // ------------------------------------------------------------------------
    // Control FSM and datapath. Abort is sampled on the clock edge, so a
    // strobe already visible in the abort cycle is not withdrawn; only the
    // transfer's future is cancelled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_per_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A load that coincides with abort is treated as not
                    // having happened.
                    if (tx_load && !tx_abort) begin
                        r_sr      <= tx_parallel;
                        r_bit_cnt <= '0;
                        r_per_cnt <= '0;
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_abort) begin
                        r_state   <= ST_IDLE;
                        r_sr      <= '0;
                        r_bit_cnt <= '0;
                        r_per_cnt <= '0;
                    end else if (w_strobe) begin
                        // Receiver takes the current bit on this edge, so
                        // the next bit moves into sr[0] right here.
                        r_sr      <= {1'b0, r_sr[NUM_BITS-1:1]};
                        r_per_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_per_cnt <= r_per_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // One-cycle done state; abort here simply lands in IDLE
                    // as well. Counters are cleared because the bit counter
                    // does not wrap to zero when NUM_BITS is not a power of
                    // two.
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                    r_per_cnt <= '0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_sr      <= '0;
                    r_bit_cnt <= '0;
                    r_per_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are pure decodes of registered state, so no input reaches an
    // output combinationally and reset forces them low/idle asynchronously.
    // ------------------------------------------------------------------------
    assign tx_ready        = (r_state == ST_IDLE);
    assign tx_data         = (r_state == ST_SEND) && r_sr[0];
    assign tx_shift_enable = w_strobe;
    assign tx_done         = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pts_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pts_tx
// Purpose  : Self-checking bench for pts_tx. Two instances share one clock
//            and reset: one with a 1-cycle bit period, one with a 4-cycle
//            bit period. Expected per-cycle outputs come from the load-to-
//            output timing formulas (bit k driven in cycles 1+k*C..(k+1)*C,
//            strobe in the last, done at N*C+1, ready at N*C+2), and a
//            receiver model reassembles the word from the strobes.
// Revision : 1.0  initial release
// ============================================================================
module tb_pts_tx;

    localparam int N = 128;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [1:0]   load;
    logic [1:0]   abort;
    logic [N-1:0] par0;
    logic [N-1:0] par1;
    logic [1:0]   ready;
    logic [1:0]   dat;
    logic [1:0]   se;
    logic [1:0]   done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_done_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pts_tx #(.NUM_BITS(N), .CLKS_PER_BIT(1)) u_c1 (
        .clk             (clk),
        .n_rst           (n_rst),
        .tx_load         (load[0]),
        .tx_parallel     (par0),
        .tx_abort        (abort[0]),
        .tx_ready        (ready[0]),
        .tx_data         (dat[0]),
        .tx_shift_enable (se[0]),
        .tx_done         (done[0])
    );

    pts_tx #(.NUM_BITS(N), .CLKS_PER_BIT(4)) u_c4 (
        .clk             (clk),
        .n_rst           (n_rst),
        .tx_load         (load[1]),
        .tx_parallel     (par1),
        .tx_abort        (abort[1]),
        .tx_ready        (ready[1]),
        .tx_data         (dat[1]),
        .tx_shift_enable (se[1]),
        .tx_done         (done[1])
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input int d, input logic l, input logic a, input logic [N-1:0] p);
        load[d]  = l;
        abort[d] = a;
        if (d == 0) par0 = p;
        else        par1 = p;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_ready"}, ready[d], 1);
            check({tag, "_data"},  dat[d],   0);
            check({tag, "_se"},    se[d],    0);
            check({tag, "_done"},  done[d],  0);
        end
    endtask

    // One transfer on instance d. Called at a negedge with that instance
    // idle; returns at the negedge of the first idle cycle afterwards with
    // the inputs for the next edge already driven (a chained load when
    // chain=1). abort_at > 0 raises abort in cycle abort_at after the load.
    task automatic xfer(input int d, input logic [N-1:0] w, input int abort_at,
                        input bit noise, input bit chain, input logic [N-1:0] next_w,
                        input bit expect_gap);
        int c;
        int nc;
        int t_end;
        int n_strb;
        int n_done;
        int exp_strb;
        logic [N-1:0] rx;
        logic [N-1:0] busy_word;
        c         = (d == 0) ? 1 : 4;
        nc        = N * c;
        t_end     = (abort_at > 0) ? abort_at + 1 : nc + 2;
        n_strb    = 0;
        n_done    = 0;
        rx        = '0;
        busy_word = {32{4'h5}};
        check("ready_at_load", ready[d], 1);
        drive(d, 1'b1, 1'b0, w);
        for (int t = 1; t <= t_end; t++) begin
            bit idle_now;
            bit in_send;
            bit exp_se;
            bit exp_d;
            @(negedge clk);
            idle_now = (t == t_end);
            in_send  = !idle_now && (t <= nc);
            exp_se   = in_send && ((t % c) == 0);
            exp_d    = in_send ? w[(t - 1) / c] : 1'b0;
            check("se",    se[d],    exp_se);
            check("data",  dat[d],   exp_d);
            check("done",  done[d],  !idle_now && (t == nc + 1));
            check("ready", ready[d], idle_now);
            if (se[d]) begin
                rx = {dat[d], rx[N-1:1]};
                n_strb++;
            end
            if (done[d]) begin
                n_done++;
                if (expect_gap) check("done_gap", cyc - last_done_cyc[d], nc + 2);
                last_done_cyc[d] = cyc;
            end
            if (t < t_end) begin
                if (noise && ($urandom_range(0, 3) == 0))
                    drive(d, 1'b1, (t == abort_at), busy_word);
                else
                    drive(d, 1'b0, (t == abort_at), rnd_word());
            end else begin
                drive(d, chain, 1'b0, chain ? next_w : rnd_word());
            end
        end
        if (abort_at > 0) begin
            exp_strb = ((abort_at < nc) ? abort_at : nc) / c;
            check("n_done_abort", n_done, 0);
        end else begin
            exp_strb = N;
            check("n_done", n_done, 1);
            check("rx_word", rx, w);
        end
        check("n_strobes", n_strb, exp_strb);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] w1;
        logic [N-1:0] w2;
        int           dd;
        int           ab;
        last_done_cyc[0] = 0;
        last_done_cyc[1] = 0;
        n_rst = 1'b0;
        load  = 2'b00;
        abort = 2'b00;
        par0  = '0;
        par1  = '0;

        // Reset state, then 20 idle cycles with no strobes.
        #1;
        check_idle_outputs("rst");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_se",    se,    2'b00);
            check("idle_ready", ready, 2'b11);
            check("idle_done",  done,  2'b00);
        end

        // Asynchronous reset mid-transfer kills it immediately.
        drive(0, 1'b1, 1'b0, {N{1'b1}});
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("pre_rst_se", se[0], 1);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_se",   se,   2'b00);
            check("post_rst_done", done, 2'b00);
        end

        // Basic C=1 transfer of the reference word.
        xfer(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1'b0, 1'b0, '0, 1'b0);
        // C=4, single set bit: strobe every 4 cycles, done at 513.
        xfer(1, 128'h1, 0, 1'b0, 1'b0, '0, 1'b0);
        // Loads of the 5-pattern during a transfer are ignored.
        xfer(0, {32{4'hA}}, 0, 1'b1, 1'b0, '0, 1'b0);
        xfer(1, {32{4'hA}}, 0, 1'b1, 1'b0, '0, 1'b0);
        // Abort at bit 10, immediate reload of all ones.
        xfer(0, rnd_word(), 10, 1'b0, 1'b1, {N{1'b1}}, 1'b0);
        xfer(0, {N{1'b1}}, 0, 1'b0, 1'b0, '0, 1'b0);
        // Back-to-back with load held high, on both instances.
        w1 = rnd_word();
        w2 = rnd_word();
        xfer(0, w1, 0, 1'b0, 1'b1, w2, 1'b0);
        xfer(0, w2, 0, 1'b0, 1'b0, '0, 1'b1);
        w1 = rnd_word();
        w2 = rnd_word();
        xfer(1, w1, 0, 1'b1, 1'b1, w2, 1'b0);
        xfer(1, w2, 0, 1'b1, 1'b0, '0, 1'b1);

        // Randomized transfers, with random aborts and busy-load noise.
        for (int i = 0; i < 8; i++) begin
            dd = $urandom_range(0, 1);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N * ((dd == 0) ? 1 : 4)) : 0;
            xfer(dd, rnd_word(), ab, $urandom_range(0, 1) == 1, 1'b0, '0, 1'b0);
        end

        @(negedge clk);
        check_idle_outputs("end");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
